// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared state encoding and alignment helpers for the instruction sequencer
package cpu_seq_pkg;

  localparam int STATE_W = 3;

  // Code 6 is deliberately left unused; the FSM treats it as a recovery path back to IDLE.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  // Instructions are word aligned, so the low two address bits must be zero.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - request/acknowledge handshakes between the sequencer and imem, dmem and divider
interface cpu_sequencer_if;

  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic div_start;
  logic div_done;

  // Sequencer side: issues requests, waits on acknowledges.
  modport master (
    output imem_req, dmem_req, div_start,
    input  imem_ack, dmem_ack, div_done
  );

  // Memory / divider side: sees requests, answers with acknowledges.
  modport slave (
    input  imem_req, dmem_req, div_start,
    output imem_ack, dmem_ack, div_done
  );

endinterface

// File: rtl/seq_wdt.sv
// rtl/seq_wdt.sv - wait-cycle counter that flags a handshake that never completes
module seq_wdt #(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  localparam logic [TMO_W-1:0] ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] cnt;

  // Expires in the cycle whose un-acked edge would bring the count up to the limit; a zero limit never expires.
  assign expired = en && (limit != '0) && (cnt == (limit - ONE));

  // Count waiting cycles, restarting whenever the sequencer changes state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer owning the PC
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TMO_W          = 8
) (
  input  logic                    CLK100MHZ,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic                    is_div_op,
  input  logic                    rd_en,
  input  logic                    taken_branch,
  input  logic [31:0]             branch_target,
  cpu_sequencer_if.master         bus,
  output logic [31:0]             pc,
  output logic [STATE_W-1:0]      state,
  output logic                    rf_we,
  output logic                    retire,
  output logic                    fault,
  output logic                    busy
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  state_t cur_state;
  state_t nxt_state;
  logic   div_wait;
  logic   pc_load;
  logic   wait_en;
  logic   wait_clr;
  logic   expired;
  logic   exec_to_mem;

  // A cycle spent in a handshake state without its acknowledge counts toward the timeout.
  assign wait_en = ((cur_state == S_FETCH) && !bus.imem_ack) ||
                   ((cur_state == S_MEM)   && !bus.dmem_ack) ||
                   ((cur_state == S_EXEC)  && is_div_op && !bus.div_done);

  // Any state change restarts the wait count, so each handshake gets its full budget.
  assign wait_clr    = (nxt_state != cur_state);
  assign exec_to_mem = is_load || is_store;

  seq_wdt #(
    .TMO_W (TMO_W)
  ) u_wdt (
    .clk     (CLK100MHZ),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .limit   (TMO_LIMIT),
    .expired (expired)
  );

  // State register; async reset drops every request immediately.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Remembers that the divider has already been started in this EXEC visit.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div_wait <= 1'b0;
    end else begin
      div_wait <= (cur_state == S_EXEC) && (nxt_state == S_EXEC);
    end
  end

  // PC advances only on a clean writeback.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= taken_branch ? branch_target : (pc + 32'd4);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    nxt_state     = cur_state;
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.div_start = 1'b0;
    rf_we         = 1'b0;
    retire        = 1'b0;
    pc_load       = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (run) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack)  nxt_state = S_DECODE;
        else if (expired)  nxt_state = S_FAULT;
      end
      S_DECODE: begin
        nxt_state = S_EXEC;
      end
      S_EXEC: begin
        if (!is_div_op) begin
          nxt_state = exec_to_mem ? S_MEM : S_WB;
        end else begin
          bus.div_start = !div_wait;
          if (bus.div_done) nxt_state = exec_to_mem ? S_MEM : S_WB;
          else if (expired) nxt_state = S_FAULT;
        end
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ack)  nxt_state = S_WB;
        else if (expired)  nxt_state = S_FAULT;
      end
      S_WB: begin
        if (taken_branch && !is_aligned(branch_target)) begin
          nxt_state = S_FAULT;
        end else begin
          retire    = 1'b1;
          rf_we     = rd_en && !is_store;
          pc_load   = 1'b1;
          nxt_state = run ? S_FETCH : S_IDLE;
        end
      end
      S_FAULT: begin
        nxt_state = S_FAULT;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  assign state = cur_state;
  assign fault = (cur_state == S_FAULT);
  assign busy  = (cur_state != S_IDLE) && (cur_state != S_FAULT);

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle instruction sequencer for the RV32IM core. It replaces the free-running 1..4 state counter with an FSM that owns the PC and steps fetch, decode, execute, memory and writeback. It waits on variable-latency instruction memory, data memory and the RV32M divider through req/ack handshakes. It flags a sticky fault on handshake timeout or a misaligned branch target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
TIMEOUT_CYCLES, 255, maximum wait cycles in any handshake state before FAULT; 0 disables the timeout
TMO_W, 8, width of the wait counter; TIMEOUT_CYCLES must be less than 2^TMO_W

Ports:
CLK100MHZ  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; allows new instructions to start
is_load  input  1  decoded load, valid DECODE..WB
is_store  input  1  decoded store
is_div_op  input  1  decoded div/divu/rem/remu
rd_en  input  1  decoded instruction writes rd
taken_branch  input  1  branch/jump taken, valid in WB
branch_target  input  32  target address from ALU, valid in WB
imem_ack  input  1  instruction word valid
dmem_ack  input  1  load data valid / store accepted
div_done  input  1  divider result valid
pc  output  32  current instruction address
state  output  3  FSM state code
imem_req  output  1  instruction fetch request
dmem_req  output  1  data access request
div_start  output  1  one-cycle divider start pulse
rf_we  output  1  register file write enable
retire  output  1  one-cycle pulse per completed instruction
fault  output  1  sticky error flag
busy  output  1  high in every state except IDLE and FAULT

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, all other outputs 0, wait counter 0.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Code 6 is unused; it recovers to IDLE on the next edge.
- IDLE: if run=1, go to FETCH on the next edge. Otherwise stay.
- FETCH: imem_req=1 combinationally. Sampling imem_ack=1 at a clock edge goes to DECODE. The minimum FETCH dwell is 1 cycle, when ack is already high.
- DECODE: always 1 cycle, then EXEC.
- EXEC:
  - is_div_op=0: 1 cycle.
  - is_div_op=1: div_start=1 during the first EXEC cycle only; stay until div_done=1 is sampled. A div_done seen in that same first cycle is accepted.
  - Exit to MEM if is_load or is_store, else to WB.
- MEM: dmem_req=1 until dmem_ack=1 is sampled, then WB.
- WB: always 1 cycle.
  - rf_we = rd_en & ~is_store.
  - retire=1.
  - pc <= taken_branch ? branch_target : pc+4. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Next state is FETCH if run=1, else IDLE.
- Misaligned target: taken_branch=1 with branch_target[1:0]!=0 goes to FAULT. pc is not updated, retire=0, rf_we=0.
- Timeout: the wait counter clears on entry to FETCH, MEM or a div EXEC, and increments each cycle without ack. On reaching TIMEOUT_CYCLES, go to FAULT.
- FAULT: fault=1; all requests, rf_we and retire are 0; pc frozen. Only rst_n exits.
- Acks outside their own wait state (imem_ack outside FETCH, etc.) are ignored.
- run deasserted mid-instruction: the instruction completes through WB, then IDLE. run has no effect inside FETCH/DECODE/EXEC/MEM.
- Reset mid-handshake: requests drop asynchronously with rst_n low. No partial writeback occurs.

Decomposition:
- Package cpu_seq_pkg: state encoding localparams (S_IDLE..S_FAULT), STATE_W=3, instruction alignment mask.
- Sub-module seq_wdt: the wait-counter/timeout unit, with inputs clr, en, limit and output expired. It is parameterised by TMO_W.
- The FSM and PC register stay in cpu_sequencer.

Test Plan:
- ALU op, run=1, imem_ack tied high: state 1,2,3,5, retire pulses every 4 cycles; pc 0 -> 4 -> 8; rf_we=1 when rd_en=1.
- Load with dmem_ack delayed 3 cycles: MEM held 4 cycles with dmem_req=1; retire in the cycle after ack; pc advances by 4.
- Div op with div_done after 33 cycles: div_start high exactly 1 cycle; EXEC lasts 34 cycles; pc advances by 4.
- Taken branch in WB, target 32'h0000_0100: pc=32'h100. Target 32'h0000_0102: state=7, fault=1, pc unchanged, no retire.
- TIMEOUT_CYCLES=4, imem_ack held 0: FAULT entered 4 cycles after FETCH entry; imem_req drops; a later imem_ack pulse is ignored.
- pc=32'hFFFF_FFFC, not taken: pc wraps to 0. run dropped during MEM: WB completes, state goes to IDLE, busy=0; rst_n pulse mid-FETCH: pc=RESET_PC, imem_req=0 immediately.
